// File: rtl/flight_mission_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : flight_mission_sequencer
// Description : Mission controller sequencing Idle, Ascend, Destination,
//               Descend, Landed and Abort from validated altitude and alarm
//               samples, with fault debounce and a destination dwell timer.
// Revision    : 1.0 - initial release
// ============================================================================
module flight_mission_sequencer #(
  parameter int ALT_W      = 10,
  parameter int ALT_MAX    = 768,
  parameter int ALT_GROUND = 16,
  parameter int FAULT_CNT  = 3,
  parameter int DWELL      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             launch,
  input  logic             sample_valid,
  input  logic [ALT_W-1:0] altitude,
  input  logic             temp_alarm,
  input  logic             rad_alarm,
  input  logic             oxy_low,
  input  logic             life_fail,
  output logic [2:0]       state_code,
  output logic             state_change,
  output logic             over_alt,
  output logic [2:0]       fault_cnt,
  output logic             abort
);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    ASCEND  = 3'b001,
    DEST    = 3'b010,
    DESCEND = 3'b011,
    LANDED  = 3'b100,
    ABORT   = 3'b111
  } state_t;

  localparam logic [ALT_W-1:0] C_ALT_MAX    = ALT_W'(ALT_MAX);
  localparam logic [ALT_W-1:0] C_ALT_GROUND = ALT_W'(ALT_GROUND);
  localparam logic [2:0]       C_FAULT_CNT  = 3'(FAULT_CNT);
  localparam logic [7:0]       C_DWELL      = 8'(DWELL);

  state_t     state, state_nx;
  logic [2:0] fault_nx;
  logic [7:0] dwell, dwell_nx;
  logic       over_nx;
  logic       fault, in_flight, qualify, aborting;
  logic [2:0] fault_inc;

  // Fault qualification: only valid samples while airborne count.
  assign fault     = temp_alarm | rad_alarm | oxy_low | life_fail;
  assign in_flight = (state == ASCEND) || (state == DEST) || (state == DESCEND);
  assign qualify   = sample_valid && in_flight;
  assign fault_inc = (fault_cnt == C_FAULT_CNT) ? fault_cnt : fault_cnt + 3'd1;
  assign aborting  = qualify && fault && (fault_inc == C_FAULT_CNT);

  // State, counters and all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      state_change <= 1'b0;
      fault_cnt    <= 3'd0;
      dwell        <= 8'd0;
      over_alt     <= 1'b0;
      abort        <= 1'b0;
    end else begin
      state        <= state_nx;
      state_change <= (state_nx != state);
      fault_cnt    <= fault_nx;
      dwell        <= dwell_nx;
      over_alt     <= over_nx;
      abort        <= (state_nx == ABORT);
    end
  end

  assign state_code = state;

  // Next-state logic; abort overrides any altitude or dwell transition.
  always_comb begin
    state_nx = state;
    fault_nx = fault_cnt;
    dwell_nx = dwell;
    over_nx  = over_alt;
    if (qualify) begin
      fault_nx = fault ? fault_inc : 3'd0;
    end
    case (state)
      IDLE: begin
        if (launch) state_nx = ASCEND;
      end
      ASCEND: begin
        if (sample_valid && !aborting && (altitude >= C_ALT_MAX)) begin
          state_nx = DEST;
          dwell_nx = 8'd0;
        end
      end
      DEST: begin
        if (sample_valid) begin
          over_nx = (altitude > C_ALT_MAX);
          if (!aborting) begin
            dwell_nx = dwell + 8'd1;
            if (dwell_nx == C_DWELL) state_nx = DESCEND;
          end
        end
      end
      DESCEND: begin
        if (sample_valid && !aborting && (altitude <= C_ALT_GROUND)) begin
          state_nx = LANDED;
          fault_nx = 3'd0;
        end
      end
      default: ;
    endcase
    if (aborting) state_nx = ABORT;
    // over_alt only has meaning while in DEST.
    if (state_nx != DEST) over_nx = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_flight_mission_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_flight_mission_sequencer
// Description : Scoreboard bench for flight_mission_sequencer; a behavioural
//               flight model queues expected outputs per driven cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flight_mission_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       launch = 1'b0;
  logic       sample_valid = 1'b0;
  logic [9:0] altitude = 10'd0;
  logic       temp_alarm = 1'b0, rad_alarm = 1'b0, oxy_low = 1'b0, life_fail = 1'b0;
  logic [2:0] state_code;
  logic       state_change, over_alt, abort;
  logic [2:0] fault_cnt;

  flight_mission_sequencer dut (
    .clk(clk), .rst(rst), .launch(launch), .sample_valid(sample_valid),
    .altitude(altitude), .temp_alarm(temp_alarm), .rad_alarm(rad_alarm),
    .oxy_low(oxy_low), .life_fail(life_fail), .state_code(state_code),
    .state_change(state_change), .over_alt(over_alt), .fault_cnt(fault_cnt),
    .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       chg;
    logic       ov;
    logic [2:0] fc;
    logic       ab;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // behavioural flight model
  int m_st = 0, m_fc = 0, m_dw = 0;
  bit m_ov = 0, m_chg = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_st = 0; m_fc = 0; m_dw = 0; m_ov = 0; m_chg = 0;
  endfunction

  function automatic exp_t model_step(input bit l, input bit v, input int a, input bit flt);
    int nst = m_st, nfc = m_fc, ndw = m_dw;
    bit nov = m_ov;
    exp_t e;
    bit airborne = (m_st == 1) || (m_st == 2) || (m_st == 3);
    if (airborne && v) begin
      nfc = flt ? ((m_fc + 1 > 3) ? 3 : m_fc + 1) : 0;
      if (nfc == 3) nst = 7;
      else begin
        case (m_st)
          1: if (a >= 768) begin nst = 2; ndw = 0; end
          2: begin
            ndw = m_dw + 1;
            nov = (a > 768);
            if (ndw == 8) nst = 3;
          end
          3: if (a <= 16) begin nst = 4; nfc = 0; end
          default: ;
        endcase
      end
    end else if (m_st == 0 && l) begin
      nst = 1;
    end
    if (nst != 2) nov = 0;
    m_chg = (nst != m_st);
    m_st = nst; m_fc = nfc; m_dw = ndw; m_ov = nov;
    e.st = 3'(m_st); e.chg = m_chg; e.ov = m_ov; e.fc = 3'(m_fc); e.ab = (m_st == 7);
    return e;
  endfunction

  // Drive one cycle of stimulus, queue the model's prediction, compare after the edge.
  task automatic step(input bit l, input bit v, input int a, input logic [3:0] al);
    exp_t e;
    @(negedge clk);
    launch = l; sample_valid = v; altitude = 10'(a);
    {temp_alarm, rad_alarm, oxy_low, life_fail} = al;
    exp_q.push_back(model_step(l, v, a, |al));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("state_code",   8'(state_code),   8'(e.st));
    chk("state_change", 8'(state_change), 8'(e.chg));
    chk("over_alt",     8'(over_alt),     8'(e.ov));
    chk("fault_cnt",    8'(fault_cnt),    8'(e.fc));
    chk("abort",        8'(abort),        8'(e.ab));
    launch = 0; sample_valid = 0;
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge.
  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_state",  8'(state_code),   8'd0);
    chk("rst_change", 8'(state_change), 8'd0);
    chk("rst_over",   8'(over_alt),     8'd0);
    chk("rst_fcnt",   8'(fault_cnt),    8'd0);
    chk("rst_abort",  8'(abort),        8'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    async_reset();

    // IDLE isolation: faulty high samples before launch do nothing
    for (int i = 0; i < 3; i++) step(0, 1, 900, 4'b1010);
    chk("idle_hold", 8'(state_code), 8'd0);

    // Nominal flight with boundary altitudes
    step(1, 0, 0, 4'b0000);
    chk("launch", 8'(state_code), 8'd1);
    step(0, 1, 100, 4'b0000);
    step(0, 1, 500, 4'b0000);
    step(0, 1, 767, 4'b0000);
    chk("asc_767", 8'(state_code), 8'd1);
    step(0, 1, 768, 4'b0000);
    chk("dest_entry", 8'(state_code), 8'd2);
    chk("dest_pulse", 8'(state_change), 8'd1);
    step(0, 1, 768, 4'b0000);
    chk("over_768", 8'(over_alt), 8'd0);
    step(0, 1, 769, 4'b0000);
    chk("over_769", 8'(over_alt), 8'd1);
    step(0, 0, 0, 4'b0000);
    for (int i = 0; i < 5; i++) step(0, 1, 780, 4'b0000);
    chk("dwell_7", 8'(state_code), 8'd2);
    step(0, 1, 780, 4'b0000);
    chk("dwell_8", 8'(state_code), 8'd3);
    step(0, 1, 17, 4'b0000);
    chk("desc_17", 8'(state_code), 8'd3);
    step(0, 1, 16, 4'b0000);
    chk("landed", 8'(state_code), 8'd4);
    step(1, 1, 5, 4'b1111);
    chk("landed_hold", 8'(state_code), 8'd4);

    // Fault debounce in ASCEND
    async_reset();
    step(1, 0, 0, 4'b0000);
    step(0, 1, 200, 4'b1000);
    step(0, 1, 200, 4'b0100);
    step(0, 1, 200, 4'b0000);
    chk("fc_clear", 8'(fault_cnt), 8'd0);
    step(0, 1, 200, 4'b0010);
    step(0, 1, 200, 4'b0001);
    chk("no_abort", 8'(abort), 8'd0);
    step(0, 1, 200, 4'b1000);
    chk("abort_st", 8'(state_code), 8'd7);
    chk("abort_fc", 8'(fault_cnt), 8'd3);
    step(0, 1, 10, 4'b0000);
    step(1, 0, 0, 4'b0000);

    // Abort overrides destination entry on the same sample
    async_reset();
    step(1, 0, 0, 4'b0000);
    step(0, 1, 300, 4'b0001);
    step(0, 1, 300, 4'b0001);
    step(0, 1, 800, 4'b0100);
    chk("abort_prio", 8'(state_code), 8'd7);

    // Reset mid-dwell, then full dwell on relaunch
    async_reset();
    step(1, 0, 0, 4'b0000);
    step(0, 1, 768, 4'b0000);
    for (int i = 0; i < 5; i++) step(0, 1, 780, 4'b0000);
    async_reset();
    step(1, 0, 0, 4'b0000);
    step(0, 1, 770, 4'b0000);
    for (int i = 0; i < 7; i++) step(0, 1, 780, 4'b0000);
    chk("relaunch_7", 8'(state_code), 8'd2);
    step(0, 1, 780, 4'b0000);
    chk("relaunch_8", 8'(state_code), 8'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
